// File: rtl/jtag_scan_master_pkg.sv
// -----------------------------------------------------------------------------
// jtag_master_pkg
// Shared definitions for the JTAG scan master:
//   - cmd_type_e : command encoding carried on the command interface
//   - state_e    : sequencing FSM states (also exported as a debug output)
//   - TMS pattern constants and lengths for TAP reset, IR/DR head and tail.
//     Pattern bit i is the TMS value driven during the i-th TCK of the segment.
//   - clamp_len  : limits a requested scan length to MAX_LEN bits
// -----------------------------------------------------------------------------
package jtag_master_pkg;

    typedef enum logic [1:0] {
        CMD_TAP_RESET = 2'd0,
        CMD_IR_SCAN   = 2'd1,
        CMD_DR_SCAN   = 2'd2,
        CMD_RUN_IDLE  = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_HEAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_TAIL  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [5:0] MAX_LEN = 6'd32;

    // Five TMS=1 clocks force Test-Logic-Reset from any state, the sixth
    // (TMS=0) parks the TAP in Run-Test/Idle.
    localparam logic [7:0] RESET_TMS   = 8'b0001_1111;
    localparam logic [5:0] RESET_LEN   = 6'd6;

    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [7:0] IR_HEAD_TMS = 8'b0000_0011;
    localparam logic [5:0] IR_HEAD_LEN = 6'd4;

    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [7:0] DR_HEAD_TMS = 8'b0000_0001;
    localparam logic [5:0] DR_HEAD_LEN = 6'd3;

    // Exit1 -> Update -> Run-Test/Idle (Exit1 is entered by the last shift bit)
    localparam logic [7:0] TAIL_TMS    = 8'b0000_0001;
    localparam logic [5:0] TAIL_LEN    = 6'd2;

    function automatic logic [5:0] clamp_len(input logic [5:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/jtag_scan_master_if.sv
// -----------------------------------------------------------------------------
// jtag_scan_master_if
// Command / response interface of the JTAG scan master.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_type/cmd_len/cmd_data are captured on that edge;
// the requester may change them freely afterwards. cmd_ready stays low (busy
// high) until the command completes. Completion is a one-cycle rsp_valid pulse
// with rsp_data, which is held until the next rsp_valid. There is no response
// back-pressure: the requester must be able to take rsp_data on that cycle.
//
// Signals:
//   cmd_valid  requester -> master  command offered
//   cmd_ready  master -> requester  master idle
//   cmd_type   requester -> master  TAP_RESET / IR_SCAN / DR_SCAN / RUN_IDLE
//   cmd_len    requester -> master  scan bits (1..32, >32 clamped) or TCK count
//   cmd_data   requester -> master  TDI payload, LSB first
//   rsp_valid  master -> requester  command complete pulse
//   rsp_data   master -> requester  captured TDO, right-aligned
//   busy       master -> requester  inverse of cmd_ready
// Modports: master = command issuer, slave = jtag_scan_master.
// -----------------------------------------------------------------------------
interface jtag_scan_master_if;
    import jtag_master_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    cmd_type_e   cmd_type;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output cmd_valid, cmd_type, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/jtag_tck_gen.sv
// -----------------------------------------------------------------------------
// jtag_tck_gen
// Generates TCK from the system clock: TCK_HALF clk cycles low, then TCK_HALF
// clk cycles high, repeating while run_i is 1. While run_i is 0 the phase
// counter is cleared and TCK is held low, so the first period after run_i
// rises always starts with a full low phase.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   run_i          enable TCK generation
//   tck_o          TCK pin value (registered)
//   rise_strobe_o  1 in the cycle whose closing clk edge drives TCK high
//   fall_strobe_o  1 in the cycle whose closing clk edge drives TCK low,
//                  i.e. the edge that starts the next low phase
// -----------------------------------------------------------------------------
module jtag_tck_gen #(
    parameter int unsigned TCK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tck_o,
    output logic rise_strobe_o,
    output logic fall_strobe_o
);

    localparam logic [3:0] HALF_M1 = 4'(TCK_HALF - 1);

    logic [3:0] cnt_q, cnt_d;
    logic       tck_q, tck_d;
    logic       phase_end;

    always_comb begin
        phase_end = run_i && (cnt_q == HALF_M1);
        cnt_d     = '0;
        tck_d     = 1'b0;
        if (run_i) begin
            if (phase_end) begin
                cnt_d = '0;
                tck_d = ~tck_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
                tck_d = tck_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck_o         = tck_q;
    assign rise_strobe_o = phase_end && !tck_q;
    assign fall_strobe_o = phase_end && tck_q;

endmodule

// File: rtl/jtag_scan_master.sv
// -----------------------------------------------------------------------------
// jtag_scan_master
// Executes one JTAG command at a time on a target TAP: TAP reset, IR scan,
// DR scan or a run of Run-Test/Idle clocks. The TAP is assumed to rest in
// Run-Test/Idle between commands; until a TAP reset has been issued since the
// last rst, scan/idle commands are prefixed with the reset sequence (SYNC).
//
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   bus       command/response interface (slave side)
//   tck, tms, tdi  JTAG pins to target; tdo  from target
//   state_o   current FSM state (debug)
//
// Sequencing: every non-idle state walks a segment of seg_len TCKs indexed by
// idx_q. tms/tdi are decoded from (state, idx) so they change only when the
// state/index registers change: on acceptance (start of the first low phase)
// and on fall strobes (start of each following low phase). TDO is captured
// on rise strobes.
// -----------------------------------------------------------------------------
module jtag_scan_master
    import jtag_master_pkg::*;
#(
    parameter int unsigned TCK_HALF = 2
) (
    input  logic              clk,
    input  logic              rst,
    jtag_scan_master_if.slave bus,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo,
    output state_e            state_o
);

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;

    cmd_type_e   type_q;
    logic [5:0]  len_q;
    logic [31:0] data_q;
    logic        synced_q;
    logic [31:0] sh_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;

    logic        run;
    logic        rise_strobe;
    logic        fall_strobe;
    logic        cmd_ready;
    logic        accept;
    logic [5:0]  acc_len;
    logic [5:0]  seg_len;
    logic        last_bit;
    logic        is_scan;
    state_e      after_sync;

    jtag_tck_gen #(
        .TCK_HALF (TCK_HALF)
    ) u_tck_gen (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run),
        .tck_o         (tck),
        .rise_strobe_o (rise_strobe),
        .fall_strobe_o (fall_strobe)
    );

    assign accept  = bus.cmd_valid && cmd_ready;
    assign acc_len = clamp_len(bus.cmd_len);
    assign is_scan = (type_q == CMD_IR_SCAN) || (type_q == CMD_DR_SCAN);

    // Length of the segment the current state walks through.
    always_comb begin
        case (state_q)
            ST_SYNC:  seg_len = RESET_LEN;
            ST_HEAD:  seg_len = (type_q == CMD_IR_SCAN) ? IR_HEAD_LEN : DR_HEAD_LEN;
            ST_SHIFT: seg_len = len_q;
            ST_TAIL:  seg_len = TAIL_LEN;
            default:  seg_len = 6'd1;
        endcase
    end

    assign last_bit = (idx_q == seg_len - 6'd1);

    // RUN_IDLE reuses SHIFT as a plain TMS=0 clock run with no head or tail.
    always_comb begin
        case (type_q)
            CMD_TAP_RESET: after_sync = ST_DONE;
            CMD_RUN_IDLE:  after_sync = ST_SHIFT;
            default:       after_sync = ST_HEAD;
        endcase
    end

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d = '0;
                    if (bus.cmd_type == CMD_TAP_RESET) begin
                        state_d = ST_SYNC;
                    end else if (acc_len == 6'd0) begin
                        state_d = ST_DONE;      // zero length: no TCK at all
                    end else if (!synced_q) begin
                        state_d = ST_SYNC;
                    end else if (bus.cmd_type == CMD_RUN_IDLE) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_HEAD;
                    end
                end
            end
            ST_SYNC: begin
                if (fall_strobe) begin
                    if (last_bit) begin
                        idx_d   = '0;
                        state_d = after_sync;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_HEAD: begin
                if (fall_strobe) begin
                    if (last_bit) begin
                        idx_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_SHIFT: begin
                if (fall_strobe) begin
                    if (last_bit) begin
                        idx_d   = '0;
                        state_d = is_scan ? ST_TAIL : ST_DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_TAIL: begin
                if (fall_strobe) begin
                    if (last_bit) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        cmd_ready = 1'b0;
        run       = 1'b0;
        tms       = 1'b0;
        tdi       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_SYNC: begin
                run = 1'b1;
                tms = RESET_TMS[idx_q[2:0]];
            end
            ST_HEAD: begin
                run = 1'b1;
                tms = (type_q == CMD_IR_SCAN) ? IR_HEAD_TMS[idx_q[2:0]]
                                              : DR_HEAD_TMS[idx_q[2:0]];
            end
            ST_SHIFT: begin
                run = 1'b1;
                if (is_scan) begin
                    tms = last_bit;     // last bit moves Shift -> Exit1
                    tdi = data_q[idx_q[4:0]];
                end
            end
            ST_TAIL: begin
                run = 1'b1;
                tms = TAIL_TMS[idx_q[2:0]];
            end
            default: begin
                run = 1'b0;
            end
        endcase
    end

    // ----------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q      <= CMD_TAP_RESET;
            len_q       <= '0;
            data_q      <= '0;
            synced_q    <= 1'b0;
            sh_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;

            if (accept) begin
                type_q <= bus.cmd_type;
                len_q  <= acc_len;
                data_q <= bus.cmd_data;
                sh_q   <= '0;
            end

            if ((state_q == ST_SYNC) && fall_strobe && last_bit) begin
                synced_q <= 1'b1;
            end

            // New bit enters at len-1 and older bits move down, so after
            // len_q bits the first arrival sits at bit 0 and upper bits stay 0.
            if ((state_q == ST_SHIFT) && is_scan && rise_strobe) begin
                sh_q <= (sh_q >> 1) | ({31'd0, tdo} << (len_q - 6'd1));
            end

            if (state_q == ST_DONE) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= sh_q;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = ~cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// -----------------------------------------------------------------------------
// tb_jtag_scan_master
// Drives jtag_scan_master (TCK_HALF=1) with directed and random commands.
// TDO is tied to TDI, optionally inverted per command, so the expected capture
// follows from the payload. A reference model builds the expected per-TCK TMS
// and TDI sequences from the JTAG state-walk rules and predicts latency and
// rsp_data; a monitor logs TMS/TDI at every TCK rising edge.
// -----------------------------------------------------------------------------
module tb_jtag_scan_master;
    import jtag_master_pkg::*;

    localparam int unsigned TB_HALF = 1;
    localparam int          LIMIT   = 400;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   tck, tms, tdi, tdo;
    logic   tdo_inv = 1'b0;
    state_e state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    bit synced_m = 1'b0;

    logic [31:0] exp_q[$];

    jtag_scan_master_if bus ();

    jtag_scan_master #(
        .TCK_HALF (TB_HALF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tck     (tck),
        .tms     (tms),
        .tdi     (tdi),
        .tdo     (tdo),
        .state_o (state_dbg)
    );

    // ------------------------------------------------------------ clock/target
    always #5 clk = ~clk;
    assign tdo = tdi ^ tdo_inv;

    // ----------------------------------------------------------------- monitor
    int   rise_cnt = 0;
    logic tck_prev = 1'b0;
    logic tms_log[8192];
    logic tdi_log[8192];

    always @(negedge clk) begin
        if (tck && !tck_prev) begin
            tms_log[rise_cnt % 8192] = tms;
            tdi_log[rise_cnt % 8192] = tdi;
            rise_cnt++;
        end
        tck_prev = tck;
    end

    // ------------------------------------------------------------------ checker
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------- model
    function automatic void model(input logic [1:0] t, input logic [5:0] l,
                                  input logic [31:0] d, input bit inv, input bit is_synced,
                                  output int n, output logic [63:0] e_tms,
                                  output logic [63:0] e_tdi, output logic [31:0] e_rsp);
        int          len;
        logic [63:0] mask;
        len   = (l > 6'd32) ? 32 : int'(l);
        n     = 0;
        e_tms = '0;
        e_tdi = '0;
        e_rsp = '0;
        // TAP reset sequence: explicit, or prefix when not yet synchronised
        if (t == 2'd0 || (len != 0 && !is_synced)) begin
            for (int i = 0; i < 6; i++) begin e_tms[n] = (i < 5); n++; end
        end
        if (t != 2'd0 && len != 0) begin
            if (t == 2'd1) for (int i = 0; i < 4; i++) begin e_tms[n] = (i < 2); n++; end
            if (t == 2'd2) for (int i = 0; i < 3; i++) begin e_tms[n] = (i < 1); n++; end
            for (int i = 0; i < len; i++) begin
                e_tms[n] = (t != 2'd3) && (i == len - 1);
                e_tdi[n] = (t != 2'd3) ? d[i] : 1'b0;
                n++;
            end
            if (t != 2'd3) begin
                for (int i = 0; i < 2; i++) begin e_tms[n] = (i == 0); n++; end
                mask  = (64'd1 << len) - 64'd1;
                e_rsp = (d ^ {32{inv}}) & mask[31:0];
            end
        end
    endfunction

    // ------------------------------------------------------------------ drivers
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        synced_m = 1'b0;
    endtask

    task automatic issue_cmd(input logic [1:0] t, input logic [5:0] l,
                             input logic [31:0] d, output int start);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.cmd_ready && w < LIMIT) begin @(negedge clk); w++; end
        check("ready_before_issue", 64'(bus.cmd_ready), 64'd1);
        start         = rise_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = cmd_type_e'(t);
        bus.cmd_len   = l;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        // scramble the command lines while busy; they must be ignored
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = cmd_type_e'($urandom_range(0, 3));
        bus.cmd_len   = 6'($urandom_range(0, 63));
        bus.cmd_data  = $urandom;
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [5:0] l,
                           input logic [31:0] d, input bit inv, input string tag);
        int          n_exp, start, cycles, n_obs;
        logic [63:0] e_tms, e_tdi, o_tms, o_tdi;
        logic [31:0] e_rsp, sb;
        model(t, l, d, inv, synced_m, n_exp, e_tms, e_tdi, e_rsp);
        exp_q.push_back(e_rsp);
        tdo_inv = inv;
        issue_cmd(t, l, d, start);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!bus.rsp_valid && cycles < LIMIT);
        sb = exp_q.pop_front();
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
        check({tag, "_latency"}, 64'(cycles), 64'(2 * TB_HALF * n_exp + 1));
        check({tag, "_ready_at_rsp"}, 64'(bus.cmd_ready), 64'd1);
        check({tag, "_busy_at_rsp"}, 64'(bus.busy), 64'd0);
        check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(sb));
        n_obs = rise_cnt - start;
        check({tag, "_tck_count"}, 64'(n_obs), 64'(n_exp));
        o_tms = '0;
        o_tdi = '0;
        for (int k = 0; k < n_obs && k < 64; k++) begin
            o_tms[k] = tms_log[(start + k) % 8192];
            o_tdi[k] = tdi_log[(start + k) % 8192];
        end
        check({tag, "_tms_seq"}, o_tms, e_tms);
        check({tag, "_tdi_seq"}, o_tdi, e_tdi);
        @(posedge clk);
        #1;
        check({tag, "_rsp_pulse"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_hold"}, 64'(bus.rsp_data), 64'(sb));
        if (t == 2'd0 || clamp_len(l) != 6'd0) synced_m = 1'b1;
    endtask

    // --------------------------------------------------------------------- main
    initial begin
        int          start, seen, w;
        logic [1:0]  rt;
        logic [5:0]  rl;
        int          sel;

        bus.cmd_valid = 1'b0;
        bus.cmd_type  = CMD_TAP_RESET;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;

        // asynchronous reset before the first clk edge
        #1 rst = 1'b1;
        #2;
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_tms", 64'(tms), 64'd0);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        synced_m = 1'b0;

        run_cmd(2'd2, 6'd8, $urandom, 1'b0, "dr_first_unsynced");
        do_reset();
        run_cmd(2'd0, 6'd6, 32'h0, 1'b0, "tap_reset");
        run_cmd(2'd1, 6'd4, 32'hA, 1'b0, "ir4_0xA");
        run_cmd(2'd2, 6'd32, 32'hDEADBEEF, 1'b0, "dr32_deadbeef");
        run_cmd(2'd2, 6'd0, 32'h1234, 1'b0, "dr_len0");
        run_cmd(2'd2, 6'd45, $urandom, 1'b1, "dr_clamp");
        run_cmd(2'd3, 6'd5, $urandom, 1'b0, "run_idle5");
        run_cmd(2'd1, 6'd1, $urandom, 1'b1, "ir_len1");
        do_reset();
        run_cmd(2'd2, 6'd0, $urandom, 1'b0, "len0_unsynced");
        run_cmd(2'd1, 6'd7, $urandom, 1'b0, "ir_after_len0");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            rt  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel == 0)      rl = 6'd0;
            else if (sel == 1) rl = 6'($urandom_range(33, 63));
            else               rl = 6'($urandom_range(1, 32));
            run_cmd(rt, rl, $urandom, 1'($urandom_range(0, 1)), "rand");
        end

        // reset in the middle of a DR shift
        tdo_inv = 1'b0;
        issue_cmd(2'd2, 6'd32, 32'hFFFF_FFFF, start);
        repeat (30) @(posedge clk);
        w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (!tck && w < 8);
        check("abort_pre_tck", 64'(tck), 64'd1);
        check("abort_pre_tdi", 64'(tdi), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_tck", 64'(tck), 64'd0);
        check("abort_tms", 64'(tms), 64'd0);
        check("abort_tdi", 64'(tdi), 64'd0);
        check("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        synced_m = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) seen++;
        end
        check("abort_no_rsp", 64'(seen), 64'd0);
        run_cmd(2'd2, 6'd16, $urandom, 1'b1, "dr_after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
